// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the io_* load/store bus responder
package mem_bus_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [31:0] MEM_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {MEM_IDLE, MEM_BUSY} mem_state_e;

  // Source of the registered read data presented with a response.
  typedef enum logic [1:0] {RSEL_ZERO, RSEL_RAM, RSEL_ERR} rdata_sel_e;

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - single-outstanding io_* load/store bus between the LSU and the memory responder
interface mem_responder_if;
  logic        io_reqValid;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wmask;
  logic        io_wen;
  logic [1:0]  io_size;
  logic        io_respValid;
  logic [31:0] io_rdata;
  logic        io_err;

  modport master (
    output io_reqValid, io_addr, io_wdata, io_wmask, io_wen, io_size,
    input  io_respValid, io_rdata, io_err
  );

  modport slave (
    input  io_reqValid, io_addr, io_wdata, io_wmask, io_wen, io_size,
    output io_respValid, io_rdata, io_err
  );
endinterface

// File: rtl/mem_array_bw.sv
// rtl/mem_array_bw.sv - synchronous word RAM with per-byte write enables, read-first; swappable for a foundry macro
module mem_array_bw #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clock,
  input  logic                           i_en,
  input  logic [3:0]                     i_wmask,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wmask[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - io_* bus memory responder with fixed latency; MEM_RESP_RAND_DELAY_EN adds 0..3 LFSR-driven extra cycles
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic          clock,
  input  logic          reset,
  mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
`ifdef MEM_RESP_RAND_DELAY_EN
  localparam int unsigned CW = 5;
`else
  localparam int unsigned CW = 4;
`endif
  localparam logic [CW-1:0] LAT_C   = CW'(LATENCY);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TWO = CW'(2);
  localparam logic [32:0]   SPAN    = 33'(DEPTH_WORDS) << 2;

  mem_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_lat;
  logic [31:0]   r_addr, r_wdata;
  logic [3:0]    r_wmask;
  logic          r_wen;
  logic          r_resp_valid, r_err;
  rdata_sel_e    r_rsel;

  logic          w_accept, w_from_in, w_commit, w_in_range;
  logic [31:0]   w_c_addr, w_c_wdata, w_off, w_ram_rdata, w_rdata;
  logic [3:0]    w_c_wmask, w_ram_wmask;
  logic          w_c_wen, w_ram_en;
  logic [AW-1:0] w_idx;
  logic          w_unused_size;

`ifdef MEM_RESP_RAND_DELAY_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_lat = LAT_C + {3'b000, r_lfsr[1:0]};
`else
  assign w_lat = LAT_C;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (bus.io_reqValid) begin
          w_accept    = 1'b1;
          w_state_nxt = MEM_BUSY;
          w_cnt_nxt   = w_lat;
        end
      end
      MEM_BUSY: begin
        if (r_cnt == CNT_ONE) begin
          if (bus.io_reqValid) begin
            w_accept  = 1'b1;
            w_cnt_nxt = w_lat;
          end else begin
            w_state_nxt = MEM_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = MEM_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The access commits on the edge that moves cnt to 1, so the response is visible
  // while cnt==1; a one-cycle request commits straight from the bus on its accept edge.
  assign w_from_in = w_accept && (w_lat == CNT_ONE);
  assign w_commit  = w_from_in || (r_state == MEM_BUSY && r_cnt == CNT_TWO);

  assign w_c_addr  = w_from_in ? bus.io_addr  : r_addr;
  assign w_c_wdata = w_from_in ? bus.io_wdata : r_wdata;
  assign w_c_wmask = w_from_in ? bus.io_wmask : r_wmask;
  assign w_c_wen   = w_from_in ? bus.io_wen   : r_wen;

  assign w_off      = w_c_addr - BASE_ADDR;
  assign w_in_range = {1'b0, w_off} < SPAN;
  assign w_idx      = w_off[AW+1:2];

  assign w_ram_en    = w_commit && w_in_range;
  assign w_ram_wmask = w_c_wen ? w_c_wmask : 4'b0000;

  mem_array_bw #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clock   (clock),
    .i_en    (w_ram_en),
    .i_wmask (w_ram_wmask),
    .i_addr  (w_idx),
    .i_wdata (w_c_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= MEM_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_wen        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_rsel       <= RSEL_ZERO;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= bus.io_addr;
        r_wdata <= bus.io_wdata;
        r_wmask <= bus.io_wmask;
        r_wen   <= bus.io_wen;
      end
      r_resp_valid <= w_commit;
      r_err        <= w_commit && !w_in_range;
      if (!w_commit || w_c_wen) r_rsel <= RSEL_ZERO;
      else if (!w_in_range)     r_rsel <= RSEL_ERR;
      else                      r_rsel <= RSEL_RAM;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (r_rsel)
      RSEL_RAM: w_rdata = w_ram_rdata;
      RSEL_ERR: w_rdata = MEM_ERR_RDATA;
      default:  w_rdata = '0;
    endcase
  end

  assign bus.io_respValid = r_resp_valid;
  assign bus.io_rdata     = w_rdata;
  assign bus.io_err       = r_err;

  // Size is informational; the byte mask alone decides which lanes are written.
  assign w_unused_size = ^{bus.io_size == MEM_BYTE, bus.io_size == MEM_HALF, bus.io_size == MEM_WORD};

  a_no_req_while_busy: assert property (@(posedge clock) disable iff (reset)
    !(bus.io_reqValid && r_state == MEM_BUSY && r_cnt > CNT_ONE));

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at LATENCY 1, 3 and 4
module tb_mem_responder;
  import mem_bus_pkg::*;

  localparam int N = 3;
  localparam int LAT [N] = '{1, 3, 4};
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t_acc;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst        [N];
  logic        req_valid  [N];
  logic [31:0] req_addr   [N];
  logic [31:0] req_wdata  [N];
  logic [3:0]  req_wmask  [N];
  logic        req_wen    [N];
  logic [1:0]  req_size   [N];
  logic        resp_valid [N];
  logic [31:0] resp_rdata [N];
  logic        resp_err   [N];

  mem_responder_if bus [N] ();

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign bus[g].io_reqValid = req_valid[g];
    assign bus[g].io_addr     = req_addr[g];
    assign bus[g].io_wdata    = req_wdata[g];
    assign bus[g].io_wmask    = req_wmask[g];
    assign bus[g].io_wen      = req_wen[g];
    assign bus[g].io_size     = req_size[g];
    assign resp_valid[g]      = bus[g].io_respValid;
    assign resp_rdata[g]      = bus[g].io_rdata;
    assign resp_err[g]        = bus[g].io_err;

    mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT[g])) u_dut (
      .clock (clock),
      .reset (rst[g]),
      .bus   (bus[g])
    );
  end

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sbq [N][$];
  logic [31:0] model [N][DEPTH];
  int   lat_hist [4];
  bit   hist_on = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Reference: word memory with byte-lane writes, out-of-range reads give DEAD_BEEF.
  function automatic exp_t model_apply(int i, logic [31:0] a, logic [31:0] d, logic [3:0] m, logic w);
    exp_t e;
    logic [31:0] off;
    bit inr;
    int idx;
    off = a - BASE;
    inr = off < 32'(DEPTH * 4);
    idx = int'(off >> 2);
    e.err = !inr;
    e.t_acc = 0;
    if (w) begin
      e.rdata = 32'h0;
      if (inr) for (int b = 0; b < 4; b++) if (m[b]) model[i][idx][8*b +: 8] = d[8*b +: 8];
    end else begin
      e.rdata = inr ? model[i][idx] : 32'hDEAD_BEEF;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    int lat;
    for (int i = 0; i < N; i++) begin
      if (resp_valid[i] === 1'b1) begin
        if (sbq[i].size() == 0) begin
          chk($sformatf("unexpected_resp_inst%0d", i), 32'd1, 32'd0);
        end else begin
          e = sbq[i].pop_front();
          lat = cyc - e.t_acc + 1;
          chk($sformatf("rdata_inst%0d", i), resp_rdata[i], e.rdata);
          chk($sformatf("err_inst%0d", i), {31'b0, resp_err[i]}, {31'b0, e.err});
`ifdef MEM_RESP_RAND_DELAY_EN
          chk($sformatf("latency_range_inst%0d_lat%0d", i, lat),
              32'(lat >= LAT[i] && lat <= LAT[i] + 3), 32'd1);
          if (hist_on && lat >= LAT[i] && lat <= LAT[i] + 3) lat_hist[lat - LAT[i]]++;
`else
          chk($sformatf("latency_inst%0d", i), 32'(lat), 32'(LAT[i]));
`endif
        end
      end
    end
  end

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic w, input bit b2b, input bit track);
    exp_t e;
    int n = 0;
    if (b2b) begin
      do begin @(negedge clock); n++; end while (resp_valid[i] !== 1'b1 && n < 50);
    end else begin
      while (sbq[i].size() != 0 && n < 50) begin @(negedge clock); n++; end
      @(posedge clock); #1;
    end
    if (n >= 50) chk($sformatf("issue_timeout_inst%0d", i), 32'd1, 32'd0);
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_wmask[i] = m;
    req_wen[i]   = w;
    req_size[i]  = MEM_WORD;
    req_valid[i] = 1'b1;
    if (track) begin
      e = model_apply(i, a, d, m, w);
      e.t_acc = cyc + 1;
      sbq[i].push_back(e);
    end
    @(posedge clock); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int n = 0;
    while (sbq[i].size() != 0 && n < 60) begin @(negedge clock); n++; end
    chk($sformatf("drain_inst%0d", i), 32'(sbq[i].size()), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic random_ops(input int i, input int cnt, input bit reads_only);
    logic [31:0] a;
    logic w;
    bit b2b;
    for (int k = 0; k < cnt; k++) begin
      if ($urandom_range(7) == 0)
        a = $urandom_range(1) ? BASE - 32'(4 * (1 + $urandom_range(3))) : BASE + 32'(DEPTH * 4 + 4 * $urandom_range(3));
      else
        a = BASE + 32'(4 * $urandom_range(15)) + 32'($urandom_range(3));
      w = reads_only ? 1'b0 : 1'($urandom_range(1));
      b2b = ($urandom_range(1) == 1) && (sbq[i].size() != 0);
      issue(i, a, $urandom(), 4'($urandom_range(15)), w, b2b, 1'b1);
    end
    drain(i);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
      req_wmask[i] = '0; req_wen[i] = 1'b0; req_size[i] = MEM_WORD;
    end
    for (int k = 0; k < 4; k++) lat_hist[k] = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset_valid_inst%0d", i), {31'b0, resp_valid[i]}, 32'd0);
      chk($sformatf("reset_rdata_inst%0d", i), resp_rdata[i], 32'd0);
      chk($sformatf("reset_err_inst%0d", i), {31'b0, resp_err[i]}, 32'd0);
    end
    @(posedge clock); #1;
    for (int i = 0; i < N; i++) rst[i] = 1'b0;

    // LATENCY=1: write/read, byte mask, out of range, empty mask, back-to-back
    issue(0, 32'h8000_0000, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 1'b1);
    issue(0, 32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    issue(0, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 1'b1);
    issue(0, 32'h8000_0004, 32'hAA00_0000, 4'h8, 1'b1, 1'b0, 1'b1);
    issue(0, 32'h8000_0006, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    issue(0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    issue(0, 32'h8000_1000, 32'h5A5A_5A5A, 4'hF, 1'b1, 1'b0, 1'b1);
    issue(0, 32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    issue(0, 32'h8000_0000, 32'hFFFF_0000, 4'h0, 1'b1, 1'b0, 1'b1);
    issue(0, 32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    issue(0, 32'h8000_0004, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    drain(0);

    // LATENCY=3: misaligned pair issued in the response cycle, write then read-after
    issue(1, 32'h8000_0000, 32'h5555_AAAA, 4'hF, 1'b1, 1'b0, 1'b1);
    issue(1, 32'h8000_0004, 32'h0102_0304, 4'hF, 1'b1, 1'b0, 1'b1);
    issue(1, 32'h8000_0001, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    issue(1, 32'h8000_0004, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    issue(1, 32'h8000_0004, 32'hF0F0_F0F0, 4'h5, 1'b1, 1'b1, 1'b1);
    issue(1, 32'h8000_0004, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    drain(1);

    // LATENCY=4: reset two cycles after accepting a write drops it silently
    issue(2, 32'h8000_0014, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 1'b1);
    drain(2);
    issue(2, 32'h8000_0014, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 1'b0);
    @(posedge clock); #1;
    rst[2] = 1'b1;
    @(posedge clock); #1;
    rst[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("reset_midop_no_resp", {31'b0, resp_valid[2]}, 32'd0);
    end
    issue(2, 32'h8000_0014, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    drain(2);

    // Random traffic on a preloaded window of 16 words per instance
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 16; k++) issue(i, BASE + 32'(4 * k), $urandom(), 4'hF, 1'b1, k != 0, 1'b1);
      random_ops(i, 60, 1'b0);
    end

`ifdef MEM_RESP_RAND_DELAY_EN
    hist_on = 1;
    random_ops(0, 200, 1'b1);
    hist_on = 0;
    for (int k = 0; k < 4; k++) chk($sformatf("latency_seen_extra%0d", k), 32'(lat_hist[k] > 0), 32'd1);
`endif

    for (int i = 0; i < N; i++) drain(i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the single-outstanding `io_*` load/store bus that the core's load/store unit drives.
- Accepts one request at a time and holds a word-organised SRAM model.
- Applies byte-lane write masks and returns full aligned words after a parameterised latency.
- Used in SoC simulation and as the on-chip scratch RAM; must support back-to-back requests, since misaligned accesses issue a second request in the same cycle the first response arrives.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two.
- BASE_ADDR, 32'h8000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- LATENCY, 1, cycles from request acceptance to response; legal range 1..15.

Ports:
- clock  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- io_reqValid  input  1  request strobe, single-cycle pulse from initiator
- io_respValid  output  1  response strobe, single-cycle pulse
- io_addr  input  32  byte address; bits [1:0] ignored for array indexing
- io_wdata  input  32  write data, already lane-rotated by initiator
- io_wmask  input  4  byte-lane write enables, bit i = bits [8i+7:8i]
- io_wen  input  1  1 = write, 0 = read
- io_size  input  2  access size; informational only, the mask is authoritative
- io_rdata  output  32  full aligned word at addr[31:2]; 0 for writes
- io_err  output  1  qualifies io_respValid; request address was out of range

Behaviour:
- States: IDLE, BUSY. A 4-bit down-counter `cnt` is used in BUSY.
- Reset values: state IDLE, cnt 0, io_respValid 0, io_rdata 0, io_err 0, latched request regs 0. Array contents are NOT reset.
- Acceptance: a request is accepted when io_reqValid=1 and either the state is IDLE, or the state is BUSY with cnt==1 (the response cycle).
- On accept, latch addr, wdata, wmask, wen; set cnt=LATENCY; go BUSY.
- io_reqValid in BUSY with cnt>1 is a protocol violation. The request is ignored and does not disturb the pending one; a simulation assertion fires.
- Latency: request accepted at rising edge T gives io_respValid=1 for exactly the cycle following edge T+LATENCY-1. With LATENCY=1, the response is in the cycle immediately after acceptance.
- io_respValid, io_rdata and io_err are registered outputs. They are never combinational from the request inputs.
- Response cycle: decrement cnt each BUSY cycle. When cnt reaches 1, the next edge performs the access, registers the outputs, and returns to IDLE unless a new request is accepted that same edge (back-to-back, stays BUSY).
- In-range test: addr-BASE_ADDR < DEPTH_WORDS*4, unsigned 32-bit subtract. Index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Read: io_rdata = mem[index]; io_err = 0.
- Write: for each i with wmask[i]=1, set mem[index][8i+7:8i] = wdata[8i+7:8i]. io_rdata = 0; io_err = 0. wmask=0000 is legal: no change, normal response.
- Out of range: writes are dropped. Reads return 32'hDEAD_BEEF. io_err = 1.
- Ordering: an access commits at its response edge. A read accepted at the response edge of a write observes that write.
- Reset mid-operation: the pending request is dropped, no response is ever issued for it, and any write not yet committed is lost.

Optional Feature:
- Macro: MEM_RESP_RAND_DELAY_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle. On each accept, cnt = LATENCY + lfsr[1:0], adding 0..3 extra cycles. Used to stress initiator wait states.
- Undefined: latency is exactly LATENCY and no LFSR logic exists.

Decomposition:
- Package mem_bus_pkg holds:
  - size constants MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10;
  - typedef mem_state_e {MEM_IDLE, MEM_BUSY};
  - constant MEM_ERR_RDATA = 32'hDEAD_BEEF.
- One natural sub-module: mem_array_bw, a byte-write-enable synchronous word RAM (DEPTH_WORDS x 32, 4 lane enables). It isolates the storage so it can be swapped for a foundry macro.

Test Plan:
- LATENCY=1: write addr 8000_0000, wdata 1122_3344, wmask 1111; then read the same address. Expect the write response 1 cycle after accept with rdata 0. Expect read rdata 1122_3344, io_err 0.
- Byte mask: write 8000_0004 = FFFF_FFFF (mask 1111), then write wdata AA00_0000 with mask 1000. Read 8000_0006 (offset ignored) returns AAFF_FFFF.
- Back-to-back misaligned pair, LATENCY=3: on the response cycle of a read at 8000_0001, pulse a request for 8000_0004. Expect a second response exactly 3 cycles later, with no dropped or duplicated io_respValid.
- Out of range: read 7FFF_FFFC gives rdata DEAD_BEEF and io_err 1. Write 8000_1000 (DEPTH_WORDS=1024) gives io_err 1 and memory unchanged.
- Reset mid-op: accept a write at LATENCY=4, assert reset 2 cycles later. Expect io_respValid 0 throughout, and the target word keeps its previous value on readback.
- MEM_RESP_RAND_DELAY_EN defined: 200 random reads. Every latency falls in LATENCY..LATENCY+3, all four values are observed, and data is correct.
